// File: rtl/l1_cache_maint_pkg.sv
// Shared types and step-ordering helpers for the L1 cache maintenance sequencer.
package l1_cache_maint_pkg;

    typedef enum logic [1:0] {
        FENCE_I = 2'd0,
        DFLUSH  = 2'd1,
        ICLEAR  = 2'd2,
        ALL     = 2'd3
    } maint_op_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_D_FLUSH = 3'd1,
        ST_D_CLEAR = 3'd2,
        ST_I_CLEAR = 3'd3,
        ST_DONE    = 3'd4
    } maint_state_t;

    function automatic maint_state_t first_step(maint_op_t op);
        return (op == ICLEAR) ? ST_I_CLEAR : ST_D_FLUSH;
    endfunction

    // Step that follows a completed step; the D-side always runs before the I-side.
    function automatic maint_state_t step_after(maint_state_t st, maint_op_t op);
        maint_state_t nxt;
        nxt = ST_DONE;
        case (st)
            ST_D_FLUSH: begin
                if (op == FENCE_I)  nxt = ST_I_CLEAR;
                else if (op == ALL) nxt = ST_D_CLEAR;
                else                nxt = ST_DONE;
            end
            ST_D_CLEAR: nxt = ST_I_CLEAR;
            default:    nxt = ST_DONE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/l1_cache_maint_sequencer.sv
// Sequences pipeline cache-maintenance ops into ordered, level-held flush/clear
// strobes toward the I/D L1 wrappers, with an optional per-step timeout.
module l1_cache_maint_sequencer
    import l1_cache_maint_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       req,
    input  logic [1:0] req_op,
    output logic       busy,
    output logic       ack,
    output logic       timeout_err,
    output logic       d_flush,
    output logic       d_clear,
    input  logic       d_flush_done,
    input  logic       d_clear_done,
    output logic       i_clear,
    input  logic       i_clear_done
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    maint_state_t     state_q, state_d;
    maint_op_t        op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic in_step;
    logic done_sel;
    logic tmo_hit;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            op_q    <= FENCE_I;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign in_step = (state_q == ST_D_FLUSH) || (state_q == ST_D_CLEAR) ||
                     (state_q == ST_I_CLEAR);

    // Only the done that matches the current step counts; stale or early dones fall away here.
    always_comb begin
        done_sel = 1'b0;
        case (state_q)
            ST_D_FLUSH: done_sel = d_flush_done;
            ST_D_CLEAR: done_sel = d_clear_done;
            ST_I_CLEAR: done_sel = i_clear_done;
            default:    done_sel = 1'b0;
        endcase
    end

    assign tmo_hit = (TIMEOUT_CYCLES > 0) && in_step && !done_sel && (cnt_q == CNT_LAST);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    op_d    = maint_op_t'(req_op);
                    err_d   = 1'b0;
                    state_d = first_step(maint_op_t'(req_op));
                end
            end
            ST_D_FLUSH, ST_D_CLEAR, ST_I_CLEAR: begin
                if (done_sel || tmo_hit) begin
                    state_d = step_after(state_q, op_q);
                    if (tmo_hit) err_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // The counter restarts on every step entry and only runs while a step waits.
        if (!in_step || (state_d != state_q)) cnt_d = '0;
        else                                  cnt_d = cnt_q + CNT_W'(1);
    end

    always_comb begin
        busy        = (state_q != ST_IDLE);
        ack         = (state_q == ST_DONE);
        d_flush     = (state_q == ST_D_FLUSH);
        d_clear     = (state_q == ST_D_CLEAR);
        i_clear     = (state_q == ST_I_CLEAR);
        timeout_err = err_q;
    end

endmodule

// File: tb/tb_l1_cache_maint_sequencer.sv
// Self-checking bench: directed scenarios with hand-computed counts plus a
// randomized run, all compared every cycle against a queue-based step model.
module tb_l1_cache_maint_sequencer;

    localparam int TMO  = 8;
    localparam int S_DF = 1;
    localparam int S_DC = 2;
    localparam int S_IC = 3;

    logic       CLK  = 1'b0;
    logic       nRST = 1'b1;
    logic       req  = 1'b0;
    logic [1:0] req_op = 2'd0;
    logic       d_flush_done = 1'b0;
    logic       d_clear_done = 1'b0;
    logic       i_clear_done = 1'b0;
    logic       busy, ack, timeout_err, d_flush, d_clear, i_clear;

    int n_checks = 0;
    int n_errors = 0;

    l1_cache_maint_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .req          (req),
        .req_op       (req_op),
        .busy         (busy),
        .ack          (ack),
        .timeout_err  (timeout_err),
        .d_flush      (d_flush),
        .d_clear      (d_clear),
        .d_flush_done (d_flush_done),
        .d_clear_done (d_clear_done),
        .i_clear      (i_clear),
        .i_clear_done (i_clear_done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: an op is a queue of pending steps; the head step is the
    // one being strobed. A step lasts until its own done or TMO cycles.
    int m_steps[$];
    bit m_done    = 1'b0;
    bit m_err     = 1'b0;
    int m_age     = 0;
    int m_accepts = 0;

    function automatic bit m_strobe(input int s);
        if (m_steps.size() == 0) return 1'b0;
        return m_steps[0] == s;
    endfunction

    function automatic bit m_busy();
        return (m_steps.size() > 0) || m_done;
    endfunction

    task automatic model_step();
        bit got_done;
        got_done = 1'b0;
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_steps.size() > 0) begin
            m_age++;
            case (m_steps[0])
                S_DF:    got_done = d_flush_done;
                S_DC:    got_done = d_clear_done;
                default: got_done = i_clear_done;
            endcase
            if (got_done || m_age == TMO) begin
                if (!got_done) m_err = 1'b1;
                void'(m_steps.pop_front());
                m_age = 0;
                if (m_steps.size() == 0) m_done = 1'b1;
            end
        end else if (req) begin
            m_err = 1'b0;
            m_age = 0;
            m_accepts++;
            case (req_op)
                2'd0:    m_steps = '{S_DF, S_IC};
                2'd1:    m_steps = '{S_DF};
                2'd2:    m_steps = '{S_IC};
                default: m_steps = '{S_DF, S_DC, S_IC};
            endcase
        end
    endtask

    initial forever begin
        @(posedge CLK or negedge nRST);
        if (!nRST) begin
            m_steps.delete();
            m_done = 1'b0;
            m_err  = 1'b0;
            m_age  = 0;
        end else begin
            model_step();
        end
    end

    initial forever begin
        @(negedge CLK);
        check("cmp busy",        busy,        32'(m_busy()));
        check("cmp ack",         ack,         32'(m_done));
        check("cmp timeout_err", timeout_err, 32'(m_err));
        check("cmp d_flush",     d_flush,     32'(m_strobe(S_DF)));
        check("cmp d_clear",     d_clear,     32'(m_strobe(S_DC)));
        check("cmp i_clear",     i_clear,     32'(m_strobe(S_IC)));
    end

    // Stimulus side: a cache responder that raises done a set number of cycles
    // after each strobe rises (-1 = never), plus observation counters.
    int cyc = 0, acc_cyc = 0, ack_cyc = -1;
    int n_df = 0, n_dc = 0, n_ic = 0, n_overlap = 0, n_ack = 0;
    int df_age = 0, dc_age = 0, ic_age = 0;
    int df_dly = -1, dc_dly = -1, ic_dly = -1;
    bit tie_high = 1'b0, rnd_mode = 1'b0, inject_ic = 1'b0;

    task automatic clear_counts();
        n_df = 0; n_dc = 0; n_ic = 0; n_overlap = 0; n_ack = 0; ack_cyc = -1;
    endtask

    task automatic tick();
        int nstb;
        @(negedge CLK);
        cyc++;
        nstb = 0;
        if (d_flush) begin n_df++; nstb++; end
        if (d_clear) begin n_dc++; nstb++; end
        if (i_clear) begin n_ic++; nstb++; end
        if (nstb > 1) n_overlap++;
        if (ack) begin
            n_ack++;
            if (ack_cyc < 0) ack_cyc = cyc;
        end
        df_age = d_flush ? df_age + 1 : 0;
        dc_age = d_clear ? dc_age + 1 : 0;
        ic_age = i_clear ? ic_age + 1 : 0;
        if (rnd_mode) begin
            d_flush_done = ($urandom_range(0, 99) < 30);
            d_clear_done = ($urandom_range(0, 99) < 30);
            i_clear_done = ($urandom_range(0, 99) < 30);
            req          = ($urandom_range(0, 99) < 25);
            req_op       = 2'($urandom_range(0, 3));
        end else begin
            d_flush_done = tie_high || (d_flush && df_dly >= 0 && df_age == df_dly + 1);
            d_clear_done = tie_high || (d_clear && dc_dly >= 0 && dc_age == dc_dly + 1);
            i_clear_done = tie_high || inject_ic ||
                           (i_clear && ic_dly >= 0 && ic_age == ic_dly + 1);
        end
    endtask

    task automatic start_op(input logic [1:0] op);
        req     = 1'b1;
        req_op  = op;
        acc_cyc = cyc;
        tick();
        req     = 1'b0;
    endtask

    task automatic wait_ack(input string name, input int budget);
        for (int i = 0; i < budget && ack_cyc < 0; i++) tick();
        check({name, " ack seen"}, 32'(ack_cyc >= 0), 32'd1);
    endtask

    initial begin
        #1 nRST = 1'b0;
        repeat (3) tick();
        check("reset busy",        busy,        0);
        check("reset ack",         ack,         0);
        check("reset timeout_err", timeout_err, 0);
        check("reset d_flush",     d_flush,     0);
        check("reset d_clear",     d_clear,     0);
        check("reset i_clear",     i_clear,     0);
        nRST = 1'b1;
        repeat (2) tick();

        // FENCE_I: D flush done after 5 cycles, I clear done after 3.
        df_dly = 5; dc_dly = -1; ic_dly = 3;
        clear_counts();
        start_op(2'd0);
        wait_ack("fence_i", 40);
        tick();
        check("fence_i latency",   32'(ack_cyc - acc_cyc), 11);
        check("fence_i d_flush",   n_df, 6);
        check("fence_i i_clear",   n_ic, 4);
        check("fence_i d_clear",   n_dc, 0);
        check("fence_i overlap",   n_overlap, 0);
        check("fence_i ack width", n_ack, 1);
        check("fence_i busy drop", busy, 0);

        // ALL with every done tied high: one cycle per step.
        tie_high = 1'b1;
        clear_counts();
        start_op(2'd3);
        wait_ack("all_tied", 20);
        tick();
        tie_high = 1'b0;
        check("all_tied latency", 32'(ack_cyc - acc_cyc), 4);
        check("all_tied d_flush", n_df, 1);
        check("all_tied d_clear", n_dc, 1);
        check("all_tied i_clear", n_ic, 1);
        check("all_tied overlap", n_overlap, 0);
        tick();

        // DFLUSH with no done ever: times out after 8 strobe cycles.
        df_dly = -1;
        clear_counts();
        start_op(2'd1);
        wait_ack("timeout", 40);
        tick();
        check("timeout latency", 32'(ack_cyc - acc_cyc), 9);
        check("timeout d_flush", n_df, 8);
        check("timeout err",     timeout_err, 1);
        ic_dly = 0;
        clear_counts();
        start_op(2'd2);
        check("timeout err cleared", timeout_err, 0);
        wait_ack("iclear", 20);
        tick();
        check("iclear min latency", 32'(ack_cyc - acc_cyc), 2);
        check("iclear err",         timeout_err, 0);

        // req held 20 sampled edges, ICLEAR with a 2-cycle done: 5 ops.
        ic_dly = 1;
        clear_counts();
        req = 1'b1; req_op = 2'd2;
        repeat (20) tick();
        req = 1'b0;
        repeat (6) tick();
        check("held acks",    n_ack, 5);
        check("held i_clear", n_ic, 10);
        check("held overlap", n_overlap, 0);
        check("held idle",    busy, 0);

        // Stale i_clear_done during D_FLUSH must not complete the later I_CLEAR.
        df_dly = 4; ic_dly = 2;
        clear_counts();
        start_op(2'd0);
        inject_ic = 1'b1;
        tick();
        inject_ic = 1'b0;
        wait_ack("stale", 40);
        tick();
        check("stale d_flush", n_df, 5);
        check("stale i_clear", n_ic, 3);
        check("stale latency", 32'(ack_cyc - acc_cyc), 9);

        // Reset asserted while in D_CLEAR.
        df_dly = 1; dc_dly = 3; ic_dly = 1;
        clear_counts();
        start_op(2'd3);
        for (int i = 0; i < 20 && !d_clear; i++) tick();
        check("rst reached d_clear", d_clear, 1);
        #2 nRST = 1'b0;
        #1;
        check("rst async busy",    busy,    0);
        check("rst async d_clear", d_clear, 0);
        check("rst async d_flush", d_flush, 0);
        check("rst async i_clear", i_clear, 0);
        check("rst async ack",     ack,     0);
        clear_counts();
        repeat (3) tick();
        nRST = 1'b1;
        repeat (2) tick();
        check("rst no ack",  n_ack, 0);
        check("rst no strb", 32'(n_df + n_dc + n_ic), 0);
        ic_dly = 0;
        clear_counts();
        start_op(2'd2);
        wait_ack("post_rst", 20);
        check("post_rst latency", 32'(ack_cyc - acc_cyc), 2);
        repeat (2) tick();

        // Randomized traffic; the per-cycle compare carries the checking.
        rnd_mode = 1'b1;
        repeat (2000) tick();
        rnd_mode = 1'b0;
        req = 1'b0;
        df_dly = 0; dc_dly = 0; ic_dly = 0;
        repeat (30) tick();
        check("random drained", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
